watchdog_multi_top: RTL
=======================

// Module: watchdog_multi_top
// PURPOSE
//  Parametrised, multi-channel windowed watchdog; successor to the single-channel watchdog_top.
//  Host writes over the shared ABUS/DBUS bus, gated by an AA/55 unlock sequence.
//  Each channel has its own frame/service/reset-limit registers, kick window, fail status and reset-hold output.
//  Sits between the system bus and the board reset tree.
// PARAMETERS
//  NCH  4  number of watchdog channels (1..16)
//  DW   8  DBUS width; also width of every per-channel counter and register
//  CHW  $clog2(NCH) (min 1)  channel-select bits in ABUS
//  PSW  2  prescaler width (used only with WD_PRESCALE_EN)
// PORTS
//  CLK     in   1        system clock, rising edge
//  RST     in   1        reset, asynchronous, active-low
//  ABUS    in   CHW+2    [1:0] register select, [CHW+1:2] channel select
//  DBUS    in   DW       write data / unlock pattern, sampled every cycle
//  RSTOUT  out  NCH      per-channel reset hold, active-high
//  WDFAIL  out  NCH      per-channel sticky fail flag
//  FLSTAT  out  2*NCH    per-channel fail code, bits [2c+1:2c]: 00 none, 01 timeout, 10 early kick, 11 double kick
//  WINOPEN out  1        write window active (debug)
// BEHAVIOUR
//  Reset: all outputs 0; FRAME/SVC/RSTLIM = 0; all channels IDLE; unlock FSM LOCKED.
//  Unlock FSM, states LOCKED -> ARMED -> WRITE(4 cycles) -> LOCKED:
//   - LOCKED->ARMED: DBUS==8'hAA and ABUS[1:0]==00.
//   - ARMED stays ARMED while DBUS==AA.
//   - ARMED->WRITE: DBUS==8'h55 and ABUS[1:0]==00.
//   - ARMED->LOCKED: any other value.
//  WRITE: the next 4 cycles are write cycles. DBUS goes to reg ABUS[1:0] of channel ABUS[CHW+1:2].
//   - AA/55 seen during WRITE are plain data.
//   - Channel index >= NCH: write ignored.
//   - Window always lasts exactly 4 cycles, then returns to LOCKED.
//  Register map:
//   - 00 FRAME: frame length in ticks.
//   - 01 SVC: open-window length at frame end.
//   - 11 RSTLIM: reset-hold down-counter load.
//   - 10 CTRL: command strobe, not stored. bit3 INIT, bit2 KICK, bit0 CLRFAIL.
//  Channel FSM, IDLE -> RUN <-> HOLD:
//   - INIT in IDLE or RUN: cnt=0, kicked=0, state RUN. INIT is ignored when FRAME==0.
//   - RUN: cnt increments per tick over 0..FRAME-1. Window open when cnt >= FRAME-SVC; SVC>=FRAME means always open.
//   - KICK rules:
//     - KICK with window closed: fail 10.
//     - KICK with kicked==1: fail 11.
//     - Otherwise kicked=1.
//   - At cnt==FRAME-1: if kicked (including a KICK in this cycle) then cnt=0, kicked=0; else fail 01.
//   - Fail: WDFAIL=1, FLSTAT code latched (first fail wins until CLRFAIL), rcnt=RSTLIM, state HOLD.
//     Flags are registered; visible the edge after the offending cycle.
//   - HOLD: RSTOUT=1 for RSTLIM+1 cycles (rcnt down to 0), then RUN with cnt=0, kicked=0.
//     In HOLD: KICK ignored, INIT ignored, config writes accepted.
//   - Simultaneous events: INIT with KICK in the same write means INIT wins and no fail.
//     CLRFAIL with a new fail in the same cycle means the new fail wins.
//   - CLRFAIL: WDFAIL=0, FLSTAT=00 for that channel; does not end HOLD.
//   - Writing FRAME/SVC while in RUN takes effect on the next compare; cnt is not reset.
//  RST low at any time (mid-window, mid-HOLD): immediate clear to reset state.
// CONFIGURATION
//  WD_PRESCALE_EN defined: a shared PSW-bit prescaler gives 1 tick per 2^PSW CLK cycles.
//   - It applies to the frame counter only; RSTOUT hold still counts CLK cycles.
//   - INIT clears the prescaler.
//  WD_PRESCALE_EN undefined: 1 tick = 1 CLK cycle; PSW unused.
// TESTING (NCH=2, DW=8)
//  1. Unlock; ch0 FRAME=0A, SVC=03, RSTLIM=04; unlock; INIT; no kick
//     -> after 10 cycles WDFAIL[0]=1, FLSTAT[1:0]=01, RSTOUT[0]=1 for 5 cycles, then ch0 restarts.
//  2. Same config; unlock + KICK at cnt=8 -> no fail; frame restarts; WDFAIL=0.
//  3. KICK at cnt=2 -> next edge FLSTAT[1:0]=10, RSTOUT[0] high 5 cycles; ch1 unaffected.
//  4. Two KICKs in one open window -> FLSTAT[1:0]=11. CLRFAIL -> WDFAIL[0]=0, FLSTAT=00.
//  5. Sequence AA,36,55 then FRAME write -> WINOPEN stays 0, FRAME unchanged.
//     Sequence AA,AA,AA,55 -> WINOPEN=1 for exactly 4 cycles.
//  6. RST low mid-HOLD -> RSTOUT, WDFAIL, FLSTAT, WINOPEN = 0 with no clock edge.
//  7. WD_PRESCALE_EN, PSW=2, FRAME=0A, no kick -> timeout after 40 cycles; hold still 5 cycles.

Source files
------------

// File: rtl/watchdog_multi_top.sv
// watchdog_multi_top: multi-channel windowed watchdog with AA/55-unlocked register writes.
// Define WD_PRESCALE_EN to divide the frame-counter tick by 2^PSW (reset hold stays in CLK cycles).
module watchdog_multi_top #(
  parameter int unsigned NCH = 4,
  parameter int unsigned DW  = 8,
  parameter int unsigned CHW = (NCH > 1) ? $clog2(NCH) : 1,
  parameter int unsigned PSW = 2
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [CHW+1:0]     ABUS,
  input  logic [DW-1:0]      DBUS,
  output logic [NCH-1:0]     RSTOUT,
  output logic [NCH-1:0]     WDFAIL,
  output logic [2*NCH-1:0]   FLSTAT,
  output logic               WINOPEN
);

  localparam int unsigned FW = 2 * NCH;
  localparam logic [1:0] REG_FRAME  = 2'b00;
  localparam logic [1:0] REG_SVC    = 2'b01;
  localparam logic [1:0] REG_CTRL   = 2'b10;
  localparam logic [1:0] REG_RSTLIM = 2'b11;
  localparam logic [DW-1:0] PAT_AA  = DW'(8'hAA);
  localparam logic [DW-1:0] PAT_55  = DW'(8'h55);

  typedef enum logic [1:0] {U_LOCKED, U_ARMED, U_WRITE} ustate_t;
  typedef enum logic [1:0] {C_IDLE, C_RUN, C_HOLD} cstate_t;

  ustate_t        ust_q, ust_d;
  logic [1:0]     wcnt_q, wcnt_d;
  logic           winopen_q, winopen_d;

  cstate_t        cst_q [NCH];
  cstate_t        cst_d [NCH];
  logic [DW-1:0]  frame_q [NCH];
  logic [DW-1:0]  frame_d [NCH];
  logic [DW-1:0]  svc_q [NCH];
  logic [DW-1:0]  svc_d [NCH];
  logic [DW-1:0]  rstlim_q [NCH];
  logic [DW-1:0]  rstlim_d [NCH];
  logic [DW-1:0]  cnt_q [NCH];
  logic [DW-1:0]  cnt_d [NCH];
  logic [DW-1:0]  rcnt_q [NCH];
  logic [DW-1:0]  rcnt_d [NCH];
  logic [NCH-1:0] kicked_q, kicked_d;
  logic [NCH-1:0] wdfail_q, wdfail_d;
  logic [NCH-1:0] rstout_q, rstout_d;
  logic [FW-1:0]  flstat_q, flstat_d;

  logic           wr_en;
  logic [1:0]     reg_sel;
  logic [CHW-1:0] ch_sel;
  logic [NCH-1:0] sel_c, init_c, kick_c, clr_c, win_c, kickn_c;
  logic [1:0]     code_c [NCH];
  logic           any_init;
  logic           tick;

  assign wr_en   = (ust_q == U_WRITE);
  assign reg_sel = ABUS[1:0];
  assign ch_sel  = ABUS[CHW+1:2];

  // Unlock sequencer: LOCKED -> ARMED (AA) -> WRITE (55) for exactly 4 cycles
  always_comb begin
    ust_d  = ust_q;
    wcnt_d = wcnt_q;
    case (ust_q)
      U_LOCKED: if (DBUS == PAT_AA && reg_sel == REG_FRAME) ust_d = U_ARMED;
      U_ARMED: begin
        if (DBUS == PAT_AA) begin
          ust_d = U_ARMED;
        end else if (DBUS == PAT_55 && reg_sel == REG_FRAME) begin
          ust_d  = U_WRITE;
          wcnt_d = 2'd0;
        end else begin
          ust_d = U_LOCKED;
        end
      end
      U_WRITE: begin
        wcnt_d = wcnt_q + 2'd1;
        if (wcnt_q == 2'd3) ust_d = U_LOCKED;
      end
      default: ust_d = U_LOCKED;
    endcase
    winopen_d = (ust_d == U_WRITE);
  end

  // Per-channel write decode; channel indices >= NCH never match
  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      sel_c[c]  = wr_en && (ch_sel == CHW'(c));
      init_c[c] = sel_c[c] && (reg_sel == REG_CTRL) && DBUS[3];
      kick_c[c] = sel_c[c] && (reg_sel == REG_CTRL) && DBUS[2];
      clr_c[c]  = sel_c[c] && (reg_sel == REG_CTRL) && DBUS[0];
    end
    any_init = |init_c;
  end

`ifdef WD_PRESCALE_EN
  logic [PSW-1:0] psc_q, psc_d;

  // Shared frame-tick prescaler, restarted by any INIT strobe
  always_comb begin
    psc_d = any_init ? '0 : psc_q + PSW'(1);
  end

  // Prescaler register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) psc_q <= '0;
    else      psc_q <= psc_d;
  end

  assign tick = &psc_q;
`else
  logic unused_psw;
  assign unused_psw = ^{any_init, PSW[0]};
  assign tick = 1'b1;
`endif

  // Channel FSMs: config writes, kick window checks, fail latching, reset hold
  always_comb begin
    flstat_d = flstat_q;
    for (int c = 0; c < NCH; c++) begin
      cst_d[c]    = cst_q[c];
      frame_d[c]  = frame_q[c];
      svc_d[c]    = svc_q[c];
      rstlim_d[c] = rstlim_q[c];
      cnt_d[c]    = cnt_q[c];
      rcnt_d[c]   = rcnt_q[c];
      kicked_d[c] = kicked_q[c];
      wdfail_d[c] = wdfail_q[c];
      code_c[c]   = 2'b00;
      kickn_c[c]  = kicked_q[c];
      win_c[c]    = (svc_q[c] >= frame_q[c]) || (cnt_q[c] >= frame_q[c] - svc_q[c]);

      if (sel_c[c] && reg_sel == REG_FRAME)  frame_d[c]  = DBUS;
      if (sel_c[c] && reg_sel == REG_SVC)    svc_d[c]    = DBUS;
      if (sel_c[c] && reg_sel == REG_RSTLIM) rstlim_d[c] = DBUS;

      if (clr_c[c]) begin
        wdfail_d[c]       = 1'b0;
        flstat_d[2*c +: 2] = 2'b00;
      end

      case (cst_q[c])
        C_IDLE: begin
          if (init_c[c] && frame_q[c] != '0) begin
            cst_d[c]    = C_RUN;
            cnt_d[c]    = '0;
            kicked_d[c] = 1'b0;
          end
        end
        C_RUN: begin
          if (init_c[c] && frame_q[c] != '0) begin
            cnt_d[c]    = '0;
            kicked_d[c] = 1'b0;
          end else begin
            if (kick_c[c]) begin
              if (!win_c[c])        code_c[c] = 2'b10;
              else if (kicked_q[c]) code_c[c] = 2'b11;
              else                  kickn_c[c] = 1'b1;
            end
            kicked_d[c] = kickn_c[c];
            if (code_c[c] == 2'b00 && tick) begin
              if (cnt_q[c] == frame_q[c] - DW'(1)) begin
                if (kickn_c[c]) begin
                  cnt_d[c]    = '0;
                  kicked_d[c] = 1'b0;
                end else begin
                  code_c[c] = 2'b01;
                end
              end else begin
                cnt_d[c] = cnt_q[c] + DW'(1);
              end
            end
            if (code_c[c] != 2'b00) begin
              wdfail_d[c] = 1'b1;
              if (!wdfail_q[c] || clr_c[c]) flstat_d[2*c +: 2] = code_c[c];
              rcnt_d[c]   = rstlim_q[c];
              cst_d[c]    = C_HOLD;
            end
          end
        end
        C_HOLD: begin
          if (rcnt_q[c] == '0) begin
            cst_d[c]    = C_RUN;
            cnt_d[c]    = '0;
            kicked_d[c] = 1'b0;
          end else begin
            rcnt_d[c] = rcnt_q[c] - DW'(1);
          end
        end
        default: cst_d[c] = C_IDLE;
      endcase
      rstout_d[c] = (cst_d[c] == C_HOLD);
    end
  end

  // State and output registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ust_q     <= U_LOCKED;
      wcnt_q    <= 2'd0;
      winopen_q <= 1'b0;
      kicked_q  <= '0;
      wdfail_q  <= '0;
      rstout_q  <= '0;
      flstat_q  <= '0;
      for (int c = 0; c < NCH; c++) begin
        cst_q[c]    <= C_IDLE;
        frame_q[c]  <= '0;
        svc_q[c]    <= '0;
        rstlim_q[c] <= '0;
        cnt_q[c]    <= '0;
        rcnt_q[c]   <= '0;
      end
    end else begin
      ust_q     <= ust_d;
      wcnt_q    <= wcnt_d;
      winopen_q <= winopen_d;
      kicked_q  <= kicked_d;
      wdfail_q  <= wdfail_d;
      rstout_q  <= rstout_d;
      flstat_q  <= flstat_d;
      for (int c = 0; c < NCH; c++) begin
        cst_q[c]    <= cst_d[c];
        frame_q[c]  <= frame_d[c];
        svc_q[c]    <= svc_d[c];
        rstlim_q[c] <= rstlim_d[c];
        cnt_q[c]    <= cnt_d[c];
        rcnt_q[c]   <= rcnt_d[c];
      end
    end
  end

  assign RSTOUT  = rstout_q;
  assign WDFAIL  = wdfail_q;
  assign FLSTAT  = flstat_q;
  assign WINOPEN = winopen_q;

endmodule
